bus_mem_ctrl: RTL and testbench
===============================

Name: bus_mem_ctrl

Overview:
External bus slave that sits directly downstream of cpu_core's multiplexed bus. It consumes DataOut/ALE/nME/nOE/ENB and returns DataIn/nWait. Each bus cycle is translated into a single-cycle strobe on a synchronous on-chip memory port, with a programmable number of wait states. It is the memory-side stage the core's stimulus bench is wired against.

Parameters:
ADDR_W, 10, memory port address width
MEM_WORDS, 1024, number of implemented words; addresses >= MEM_WORDS are out of range
WAIT_CYCLES, 2, extra wait states per access, legal range 0..15

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
DataOut  input  16  core bus output; carries the address while ALE=1 and write data during a write
ALE  input  1  address latch enable
nME  input  1  memory enable, active low; low for the whole bus cycle
nOE  input  1  output enable, active low; 0 = read cycle
ENB  input  1  core bus-drive enable; 1 with nOE=1 = write cycle
DataIn  output  16  read data to the core
nWait  output  1  wait request, active low
MemAddr  output  ADDR_W  memory address
MemWData  output  16  memory write data
MemWe  output  1  memory write strobe, one cycle
MemRe  output  1  memory read strobe, one cycle
MemRData  input  16  memory read data, valid the cycle after MemRe
BusErr  output  1  one-cycle error pulse

Behaviour:
- All outputs are registered. Reset (sync, high) gives: state=IDLE, DataIn=0, nWait=1, MemAddr=0, MemWData=0, MemWe=0, MemRe=0, BusErr=0, addr reg=0. Reset mid-access aborts the access and issues no strobe on the following cycle.
- States and transitions:
  - IDLE: ALE=1 latches the full 16-bit DataOut into the addr reg and moves to ADDR. All other inputs are ignored.
  - ADDR: ALE=1 re-latches the address and stays in ADDR. nME=0 registers the op and moves on:
    - read if nOE=0; write if nOE=1 and ENB=1.
    - If nOE=0 and ENB=1: treat as read and pulse BusErr.
    - If nOE=1 and ENB=0: null op; go to HOLD with no strobe and no wait.
    - Next state is WAIT with cnt=WAIT_CYCLES-1 if WAIT_CYCLES>0, else ACCESS.
  - WAIT: nWait=0. cnt decrements each cycle; at cnt=0 go to ACCESS.
  - ACCESS: nWait=0.
    - Out of range (addr >= MEM_WORDS): no strobe, BusErr=1 for this cycle.
    - Read in range: MemRe=1 and MemAddr=addr[ADDR_W-1:0].
    - Write in range: MemWe=1, MemAddr as for read, MemWData=DataOut sampled this cycle.
    - Always go to DATA.
  - DATA: nWait=0. For a read, DataIn<=MemRData (0xFFFF if out of range) at the end of this cycle. Go to HOLD.
  - HOLD: nWait=1, DataIn held. nME=1 clears DataIn to 0 and returns to IDLE.
- nWait is low only in WAIT, ACCESS and DATA: exactly WAIT_CYCLES+2 cycles. Read data is valid on the first cycle nWait is high again.
- Strobes are never asserted for more than one cycle, and never both at once.
- Abort: nME=1 seen in ADDR, WAIT, ACCESS or DATA returns to IDLE next cycle with nWait=1 and DataIn=0.
  - If the abort is seen in ACCESS, that cycle's strobe is suppressed (abort has priority).
  - If seen in DATA, the already-issued strobe stands and DataIn is not loaded.
- ALE in WAIT, ACCESS, DATA or HOLD is ignored. The address is stable for the whole cycle.
- Back-to-back accesses: the HOLD->IDLE transition and ALE may coincide. ALE=1 with nME=1 in HOLD latches the address and goes directly to ADDR.

Test Plan:
- Read, WAIT_CYCLES=2, MEM[0x012]=0xBEEF, ALE with DataOut=0x0012 then nME=0,nOE=0 -> nWait low 4 cycles; one MemRe with MemAddr=0x012; DataIn=0xBEEF when nWait rises; DataIn=0 the cycle after nME=1.
- Write, addr 0x0034, nOE=1, ENB=1, DataOut=0xA5A5 during wait -> a single MemWe with MemAddr=0x034 and MemWData=0xA5A5; a readback of 0x0034 returns 0xA5A5.
- Out-of-range read at 0x0400 (MEM_WORDS=1024) -> no MemRe; BusErr one cycle in ACCESS; DataIn=0xFFFF.
- Abort: nME returns high in the 2nd WAIT cycle -> no MemRe/MemWe; nWait=1 and state=IDLE next cycle; the next normal read succeeds.
- Reset asserted in ACCESS -> no strobe the following cycle; all outputs at reset values; the read after reset completes correctly.
- WAIT_CYCLES=0 build: a read holds nWait low exactly 2 cycles; back-to-back reads to 0x0001 and 0x0002 (ALE coincident with nME release) return the correct data for both.

Source files
------------

// File: rtl/bus_mem_ctrl.sv
// Bus slave bridging the core's multiplexed ALE/nME/nOE bus onto a synchronous memory port.
// Each bus cycle produces at most one read or write strobe, with a programmable number of wait states.
module bus_mem_ctrl #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       DataOut,
  input  logic              ALE,
  input  logic              nME,
  input  logic              nOE,
  input  logic              ENB,
  output logic [15:0]       DataIn,
  output logic              nWait,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [15:0]       MemWData,
  output logic              MemWe,
  output logic              MemRe,
  input  logic [15:0]       MemRData,
  output logic              BusErr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WAIT   = 3'd2,
    S_ACCESS = 3'd3,
    S_DATA   = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 32'd0) ? 4'(WAIT_CYCLES - 32'd1) : 4'd0;

  state_t      state_r;
  logic [15:0] addr_r;
  logic [3:0]  cnt_r;
  logic        opRead_r;
  logic        opWrite_r;

  logic decRead_s;
  logic decWrite_s;
  logic decConflict_s;
  logic addrGo_s;
  logic useRead_s;
  logic useWrite_s;
  logic enterAccess_s;
  logic inRange_s;

  assign inRange_s = ({16'd0, addr_r} < MEM_WORDS);

  // Decode the bus op and decide whether this cycle's edge enters ACCESS (strobes are issued on that edge).
  always_comb begin
    decRead_s     = 1'b0;
    decWrite_s    = 1'b0;
    decConflict_s = 1'b0;
    if (!nOE) begin
      decRead_s     = 1'b1;
      decConflict_s = ENB;
    end else if (ENB) begin
      decWrite_s = 1'b1;
    end else begin
      decRead_s = 1'b0;
    end

    addrGo_s = (state_r == S_ADDR) && !ALE && !nME;

    if (state_r == S_ADDR) begin
      useRead_s  = decRead_s;
      useWrite_s = decWrite_s;
    end else begin
      useRead_s  = opRead_r;
      useWrite_s = opWrite_r;
    end

    // An abort seen on the entering edge wins over the strobe.
    if (addrGo_s) begin
      enterAccess_s = (WAIT_CYCLES == 32'd0) && (decRead_s || decWrite_s);
    end else if (state_r == S_WAIT) begin
      enterAccess_s = !nME && (cnt_r == 4'd0);
    end else begin
      enterAccess_s = 1'b0;
    end
  end

  // Bus FSM with all outputs registered so they line up with the state they belong to.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r   <= S_IDLE;
      addr_r    <= 16'd0;
      cnt_r     <= 4'd0;
      opRead_r  <= 1'b0;
      opWrite_r <= 1'b0;
      DataIn    <= 16'd0;
      nWait     <= 1'b1;
      MemAddr   <= '0;
      MemWData  <= 16'd0;
      MemWe     <= 1'b0;
      MemRe     <= 1'b0;
      BusErr    <= 1'b0;
    end else begin
      MemRe  <= enterAccess_s && useRead_s && inRange_s;
      MemWe  <= enterAccess_s && useWrite_s && inRange_s;
      BusErr <= (enterAccess_s && !inRange_s) || (addrGo_s && decConflict_s);
      if (enterAccess_s && inRange_s) begin
        MemAddr <= addr_r[ADDR_W-1:0];
        if (useWrite_s) begin
          MemWData <= DataOut;
        end
      end

      case (state_r)
        S_IDLE: begin
          nWait <= 1'b1;
          if (ALE) begin
            addr_r  <= DataOut;
            state_r <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (ALE) begin
            addr_r <= DataOut;
          end else if (nME) begin
            state_r <= S_IDLE;
          end else begin
            opRead_r  <= decRead_s;
            opWrite_r <= decWrite_s;
            if (!(decRead_s || decWrite_s)) begin
              state_r <= S_HOLD;
            end else if (enterAccess_s) begin
              state_r <= S_ACCESS;
              nWait   <= 1'b0;
            end else begin
              state_r <= S_WAIT;
              cnt_r   <= CNT_INIT;
              nWait   <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (nME) begin
            state_r <= S_IDLE;
            nWait   <= 1'b1;
            DataIn  <= 16'd0;
          end else if (enterAccess_s) begin
            state_r <= S_ACCESS;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_ACCESS: begin
          if (nME) begin
            state_r <= S_IDLE;
            nWait   <= 1'b1;
            DataIn  <= 16'd0;
          end else begin
            state_r <= S_DATA;
          end
        end
        S_DATA: begin
          if (nME) begin
            state_r <= S_IDLE;
            nWait   <= 1'b1;
            DataIn  <= 16'd0;
          end else begin
            state_r <= S_HOLD;
            nWait   <= 1'b1;
            if (opRead_r) begin
              DataIn <= inRange_s ? MemRData : 16'hFFFF;
            end
          end
        end
        S_HOLD: begin
          nWait <= 1'b1;
          if (nME) begin
            DataIn <= 16'd0;
            if (ALE) begin
              addr_r  <= DataOut;
              state_r <= S_ADDR;
            end else begin
              state_r <= S_IDLE;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          nWait   <= 1'b1;
          DataIn  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Directed bench for bus_mem_ctrl: a 2-wait-state build and a zero-wait build share one bus,
// each backed by a small synchronous memory model.
module tb_bus_mem_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] DataOut;
  logic        ALE, nME, nOE, ENB;

  logic [15:0] dinA, wdA, rdA, dinB, wdB, rdB;
  logic [9:0]  addrA, addrB;
  logic        nWaitA, weA, reA, errA, nWaitB, weB, reB, errB;

  logic [15:0] memA [0:1023];
  logic [15:0] memB [0:1023];
  int          reCntA = 0, weCntA = 0, reCntB = 0, bothCnt = 0;
  logic [9:0]  lastReAddrA = 10'd0, lastWeAddrA = 10'd0, lastReAddrB = 10'd0;
  logic [15:0] lastWdA = 16'd0;

  int testCnt = 0;
  int failCnt = 0;

  always #5 Clock = ~Clock;

  bus_mem_ctrl #(.ADDR_W(10), .MEM_WORDS(1024), .WAIT_CYCLES(2)) dutA (
    .Clock(Clock), .Reset(Reset), .DataOut(DataOut), .ALE(ALE), .nME(nME), .nOE(nOE), .ENB(ENB),
    .DataIn(dinA), .nWait(nWaitA), .MemAddr(addrA), .MemWData(wdA), .MemWe(weA), .MemRe(reA),
    .MemRData(rdA), .BusErr(errA)
  );

  bus_mem_ctrl #(.ADDR_W(10), .MEM_WORDS(1024), .WAIT_CYCLES(0)) dutB (
    .Clock(Clock), .Reset(Reset), .DataOut(DataOut), .ALE(ALE), .nME(nME), .nOE(nOE), .ENB(ENB),
    .DataIn(dinB), .nWait(nWaitB), .MemAddr(addrB), .MemWData(wdB), .MemWe(weB), .MemRe(reB),
    .MemRData(rdB), .BusErr(errB)
  );

  // Synchronous memories (read data valid the cycle after MemRe) plus strobe bookkeeping.
  always @(posedge Clock) begin
    if (Reset) begin
      memA[10'h012] <= 16'hBEEF;
      memB[10'h001] <= 16'h1111;
      memB[10'h002] <= 16'h2222;
    end
    if (reA) begin rdA <= memA[addrA]; reCntA <= reCntA + 1; lastReAddrA <= addrA; end
    if (weA) begin memA[addrA] <= wdA; weCntA <= weCntA + 1; lastWeAddrA <= addrA; lastWdA <= wdA; end
    if (reB) begin rdB <= memB[addrB]; reCntB <= reCntB + 1; lastReAddrB <= addrB; end
    if (weB) memB[addrB] <= wdB;
    if ((reA && weA) || (reB && weB)) bothCnt <= bothCnt + 1;
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic busIdle();
    ALE = 1'b0; nME = 1'b1; nOE = 1'b1; ENB = 1'b0; DataOut = 16'h0000;
  endtask

  // Address phase, then leave the data-phase inputs applied for the next edge.
  task automatic addrPhase(input logic [15:0] a, input logic ro, input logic en, input logic [15:0] d);
    ALE = 1'b1; nME = 1'b1; DataOut = a;
    cyc();
    ALE = 1'b0; nME = 1'b0; nOE = ro; ENB = en; DataOut = d;
  endtask

  task automatic releaseBus();
    busIdle();
    cyc();
  endtask

  // Run until nWait rises again; bounded so a stuck DUT still reaches the summary.
  task automatic runAccess(input bit useB, output int lowCnt, output int errCnt,
                           output logic [15:0] dataAtRise, output bit timedOut);
    bit done;
    lowCnt = 0; errCnt = 0; dataAtRise = 16'h0000; timedOut = 1'b1; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc();
      if (useB ? errB : errA) errCnt++;
      if (!(useB ? nWaitB : nWaitA)) lowCnt++;
      else if (lowCnt > 0) begin
        dataAtRise = useB ? dinB : dinA;
        timedOut   = 1'b0;
        done       = 1'b1;
      end
    end
  endtask

  initial begin
    int          lowCnt, errCnt, reBase, weBase;
    logic [15:0] data;
    bit          tmo;

    Reset = 1'b1;
    busIdle();
    cyc();
    cyc();
    checkEq("rst_DataIn", dinA, 16'h0000);
    checkEq("rst_nWait", nWaitA, 1'b1);
    checkEq("rst_MemAddr", addrA, 10'h000);
    checkEq("rst_MemWData", wdA, 16'h0000);
    checkEq("rst_strobes", {reA, weA, errA}, 3'b000);
    Reset = 1'b0;
    cyc();

    // Read 0x012 with two wait states.
    reBase = reCntA; weBase = weCntA;
    addrPhase(16'h0012, 1'b0, 1'b0, 16'h0000);
    runAccess(1'b0, lowCnt, errCnt, data, tmo);
    checkEq("rd_timeout", tmo, 1'b0);
    checkEq("rd_waitlen", lowCnt, 4);
    checkEq("rd_data", data, 16'hBEEF);
    checkEq("rd_recount", reCntA - reBase, 1);
    checkEq("rd_addr", lastReAddrA, 10'h012);
    checkEq("rd_nowrite", weCntA - weBase, 0);
    releaseBus();
    checkEq("rd_dataclr", dinA, 16'h0000);

    // Write A5A5 to 0x034, then read it back.
    reBase = reCntA; weBase = weCntA;
    addrPhase(16'h0034, 1'b1, 1'b1, 16'hA5A5);
    runAccess(1'b0, lowCnt, errCnt, data, tmo);
    checkEq("wr_waitlen", lowCnt, 4);
    checkEq("wr_wecount", weCntA - weBase, 1);
    checkEq("wr_addr", lastWeAddrA, 10'h034);
    checkEq("wr_data", lastWdA, 16'hA5A5);
    checkEq("wr_noread", reCntA - reBase, 0);
    releaseBus();
    addrPhase(16'h0034, 1'b0, 1'b0, 16'h0000);
    runAccess(1'b0, lowCnt, errCnt, data, tmo);
    checkEq("wr_readback", data, 16'hA5A5);
    releaseBus();

    // Out-of-range read.
    reBase = reCntA;
    addrPhase(16'h0400, 1'b0, 1'b0, 16'h0000);
    runAccess(1'b0, lowCnt, errCnt, data, tmo);
    checkEq("oor_noread", reCntA - reBase, 0);
    checkEq("oor_buserr", errCnt, 1);
    checkEq("oor_data", data, 16'hFFFF);
    releaseBus();

    // Abort in the second wait cycle.
    reBase = reCntA; weBase = weCntA;
    addrPhase(16'h0012, 1'b0, 1'b0, 16'h0000);
    cyc();
    checkEq("abt_wait1", nWaitA, 1'b0);
    cyc();
    busIdle();
    cyc();
    checkEq("abt_nwait", nWaitA, 1'b1);
    checkEq("abt_datain", dinA, 16'h0000);
    cyc();
    cyc();
    cyc();
    checkEq("abt_nostrobe", (reCntA - reBase) + (weCntA - weBase), 0);
    addrPhase(16'h0012, 1'b0, 1'b0, 16'h0000);
    runAccess(1'b0, lowCnt, errCnt, data, tmo);
    checkEq("abt_nextrd", data, 16'hBEEF);
    releaseBus();

    // Reset while in ACCESS.
    addrPhase(16'h0012, 1'b0, 1'b0, 16'h0000);
    cyc();
    cyc();
    cyc();
    checkEq("rstacc_inaccess", reA, 1'b1);
    Reset = 1'b1;
    cyc();
    checkEq("rstacc_nostrobe", {reA, weA, errA}, 3'b000);
    checkEq("rstacc_nwait", nWaitA, 1'b1);
    checkEq("rstacc_datain", dinA, 16'h0000);
    checkEq("rstacc_memaddr", addrA, 10'h000);
    Reset = 1'b0;
    busIdle();
    cyc();
    addrPhase(16'h0034, 1'b0, 1'b0, 16'h0000);
    runAccess(1'b0, lowCnt, errCnt, data, tmo);
    checkEq("rstacc_nextrd", data, 16'hA5A5);
    releaseBus();

    // Zero-wait build: back-to-back reads with ALE coincident with nME release.
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    cyc();
    reBase = reCntB;
    addrPhase(16'h0001, 1'b0, 1'b0, 16'h0000);
    runAccess(1'b1, lowCnt, errCnt, data, tmo);
    checkEq("b_timeout1", tmo, 1'b0);
    checkEq("b_waitlen1", lowCnt, 2);
    checkEq("b_data1", data, 16'h1111);
    ALE = 1'b1; nME = 1'b1; DataOut = 16'h0002;
    cyc();
    checkEq("b_dataclr", dinB, 16'h0000);
    ALE = 1'b0; nME = 1'b0; nOE = 1'b0; ENB = 1'b0; DataOut = 16'h0000;
    runAccess(1'b1, lowCnt, errCnt, data, tmo);
    checkEq("b_waitlen2", lowCnt, 2);
    checkEq("b_data2", data, 16'h2222);
    checkEq("b_recount", reCntB - reBase, 2);
    checkEq("b_addr2", lastReAddrB, 10'h002);
    releaseBus();

    checkEq("strobe_overlap", bothCnt, 0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
